sr_driver: RTL and testbench

SR_DRIVER -- requirements
Module: sr_driver

---
 rtl/sr_driver_pkg.sv | 33 +++
 rtl/sr_cmd_check.sv | 46 ++++
 rtl/sr_driver.sv | 107 ++++++++++
 tb/tb_sr_driver.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sr_driver_pkg.sv
// Shared definitions for the SR flop driver: FSM state encoding and
// the saturation limit of the mismatch counter.
package sr_driver_pkg;

    // Two-bit state encoding, fixed so that debug probes and waveforms
    // can be decoded without the enum type.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WAIT  = 2'd2,
        CHECK = 2'd3
    } state_t;

    // Width of the mismatch counter and the value at which it stops.
    localparam int         ERR_CNT_W   = 8;
    localparam logic [7:0] ERR_CNT_MAX = 8'd255;

    // Width of the feedback latency counter (CHECK_LAT is at most 15).
    localparam int LAT_CNT_W = 4;

    // Set command needed to move the flop from its current state to the
    // requested one. Equal values mean the flop is left alone.
    function automatic logic need_set(input logic target, input logic current);
        return target && !current;
    endfunction

    // Reset command needed to move the flop from its current state to
    // the requested one.
    function automatic logic need_reset(input logic target, input logic current);
        return !target && current;
    endfunction

endpackage

// File: rtl/sr_cmd_check.sv
// Feedback checker for the SR flop driver. During the CHECK cycle it
// compares the flop's q/qbar against the commanded value and keeps the
// sticky error flag plus a saturating mismatch count.
module sr_cmd_check
    import sr_driver_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 check_en,
    input  logic                 tgt_q,
    input  logic                 q_fb,
    input  logic                 qbar_fb,
    input  logic                 clr,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic mismatch;

    // A mismatch is either q disagreeing with the command or the two
    // flop outputs not being complementary (e.g. both high).
    always_comb begin
        mismatch = 1'b0;
        if (check_en) begin
            mismatch = (q_fb != tgt_q) || (qbar_fb != ~q_fb);
        end
    end

    // Sticky flag and saturating count; a clear in the same cycle as a
    // mismatch takes priority, so that mismatch is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (clr) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (mismatch) begin
            err <= 1'b1;
            if (err_cnt != ERR_CNT_MAX) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/sr_driver.sv
// SR flop driver: accepts a requested flop value, pulses set or reset
// for one cycle when the value changes, waits CHECK_LAT cycles for the
// flop to settle, then checks its q/qbar feedback.
module sr_driver
    import sr_driver_pkg::*;
#(
    parameter int CHECK_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tgt_valid,
    input  logic                 tgt_bit,
    output logic                 tgt_ready,
    output logic                 s,
    output logic                 r,
    input  logic                 q_fb,
    input  logic                 qbar_fb,
    input  logic                 clr,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 busy
);

    // Value loaded into the wait counter; the WAIT state lasts
    // CHECK_LAT cycles because it exits on the cycle the counter is 0.
    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(CHECK_LAT - 1);

    state_t               state;
    state_t               state_next;
    logic [LAT_CNT_W-1:0] wait_cnt;
    logic                 tgt_q;
    logic                 model_q;
    logic                 accept;
    logic                 check_en;

    // Handshake and status decode straight from the state register, so
    // an asynchronous reset raises tgt_ready immediately.
    always_comb begin
        tgt_ready = (state == IDLE);
        busy      = (state != IDLE);
        accept    = tgt_valid && (state == IDLE);
        check_en  = (state == CHECK);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; requests outside IDLE are simply not looked at.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = DRIVE;
            DRIVE:   state_next = WAIT;
            WAIT:    if (wait_cnt == '0) state_next = CHECK;
            CHECK:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Command and bookkeeping registers. s/r are computed at the accepting
    // edge so they are high exactly during DRIVE, and they default to 0
    // every other cycle. model_q follows the command only, never q_fb.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s        <= 1'b0;
            r        <= 1'b0;
            tgt_q    <= 1'b0;
            model_q  <= 1'b0;
            wait_cnt <= '0;
        end else begin
            s <= 1'b0;
            r <= 1'b0;
            if (accept) begin
                tgt_q <= tgt_bit;
                s     <= need_set(tgt_bit, model_q);
                r     <= need_reset(tgt_bit, model_q);
            end
            if (state == DRIVE) begin
                model_q  <= tgt_q;
                wait_cnt <= LAT_LOAD;
            end
            if ((state == WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
        end
    end

    // Feedback comparison and error bookkeeping.
    sr_cmd_check u_check (
        .clk      (clk),
        .rst_n    (rst_n),
        .check_en (check_en),
        .tgt_q    (tgt_q),
        .q_fb     (q_fb),
        .qbar_fb  (qbar_fb),
        .clr      (clr),
        .err      (err),
        .err_cnt  (err_cnt)
    );

endmodule

// File: tb/tb_sr_driver.sv
// Directed testbench for sr_driver: one instance with CHECK_LAT=1 for
// the command/check behaviour and one with CHECK_LAT=3 for reset abort
// and latency.
module tb_sr_driver;

    logic clk = 1'b0;

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    logic       rst_n, tgt_valid, tgt_bit, tgt_ready, s, r;
    logic       q_fb, qbar_fb, clr, err, busy;
    logic [7:0] err_cnt;

    logic       rst_n_l3, tgt_valid_l3, tgt_bit_l3, tgt_ready_l3, s_l3, r_l3;
    logic       q_fb_l3, qbar_fb_l3, clr_l3, err_l3, busy_l3;
    logic [7:0] err_cnt_l3;

    int n_checks = 0;
    int n_fails  = 0;
    int n_cyc;

    sr_driver #(.CHECK_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
        .tgt_ready(tgt_ready), .s(s), .r(r), .q_fb(q_fb), .qbar_fb(qbar_fb),
        .clr(clr), .err(err), .err_cnt(err_cnt), .busy(busy)
    );

    sr_driver #(.CHECK_LAT(3)) dut_l3 (
        .clk(clk), .rst_n(rst_n_l3), .tgt_valid(tgt_valid_l3), .tgt_bit(tgt_bit_l3),
        .tgt_ready(tgt_ready_l3), .s(s_l3), .r(r_l3), .q_fb(q_fb_l3), .qbar_fb(qbar_fb_l3),
        .clr(clr_l3), .err(err_l3), .err_cnt(err_cnt_l3), .busy(busy_l3)
    );

    // One comparison: counts it and reports any difference.
    task automatic check_output(input string tag, input logic [7:0] observed,
                                input logic [7:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Full request on the CHECK_LAT=1 instance, ending on an IDLE cycle.
    task automatic apply_stimulus(input logic b);
        @(negedge clk);
        tgt_valid = 1'b1;
        tgt_bit   = b;
        @(negedge clk);
        tgt_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Directed sequence; outputs are sampled on falling edges.
    initial begin
        rst_n = 1'b0; tgt_valid = 1'b0; tgt_bit = 1'b0;
        q_fb = 1'b0; qbar_fb = 1'b1; clr = 1'b0;
        rst_n_l3 = 1'b0; tgt_valid_l3 = 1'b0; tgt_bit_l3 = 1'b0;
        q_fb_l3 = 1'b0; qbar_fb_l3 = 1'b1; clr_l3 = 1'b0;

        repeat (2) @(negedge clk);
        check_output("reset_s", s, 0);
        check_output("reset_r", r, 0);
        check_output("reset_ready", tgt_ready, 1);
        check_output("reset_busy", busy, 0);
        check_output("reset_err", err, 0);
        check_output("reset_cnt", err_cnt, 0);
        rst_n = 1'b1;
        rst_n_l3 = 1'b1;

        // Set request from reset state: one-cycle s pulse, good feedback.
        q_fb = 1'b1; qbar_fb = 1'b0;
        @(negedge clk);
        tgt_valid = 1'b1; tgt_bit = 1'b1;
        @(negedge clk);
        tgt_valid = 1'b0;
        check_output("set_drive_s", s, 1);
        check_output("set_drive_r", r, 0);
        check_output("set_drive_busy", busy, 1);
        check_output("set_drive_ready", tgt_ready, 0);
        @(negedge clk);
        check_output("set_wait_s", s, 0);
        check_output("set_wait_r", r, 0);
        @(negedge clk);
        check_output("set_check_busy", busy, 1);
        @(negedge clk);
        check_output("set_done_ready", tgt_ready, 1);
        check_output("set_done_err", err, 0);
        check_output("set_done_cnt", err_cnt, 0);

        // Same value again: hold, no command pulse.
        @(negedge clk);
        tgt_valid = 1'b1; tgt_bit = 1'b1;
        @(negedge clk);
        tgt_valid = 1'b0;
        check_output("hold_drive_s", s, 0);
        check_output("hold_drive_r", r, 0);
        check_output("hold_drive_busy", busy, 1);
        repeat (3) @(negedge clk);
        check_output("hold_done_ready", tgt_ready, 1);
        check_output("hold_done_err", err, 0);

        // Reset request while the flop stays at 1: r pulse and a mismatch.
        @(negedge clk);
        tgt_valid = 1'b1; tgt_bit = 1'b0;
        @(negedge clk);
        tgt_valid = 1'b0;
        check_output("rst_drive_r", r, 1);
        check_output("rst_drive_s", s, 0);
        @(negedge clk);
        check_output("rst_wait_r", r, 0);
        @(negedge clk);
        check_output("rst_check_err", err, 0);
        @(negedge clk);
        check_output("rst_done_err", err, 1);
        check_output("rst_done_cnt", err_cnt, 1);

        // Clear while idle.
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check_output("clr_err", err, 0);
        check_output("clr_cnt", err_cnt, 0);

        // q matches the target but qbar is also high: still a mismatch.
        qbar_fb = 1'b1;
        apply_stimulus(1'b1);
        check_output("qbar_err", err, 1);
        check_output("qbar_cnt", err_cnt, 1);

        // Clear in the same cycle as a failing CHECK discards the mismatch.
        @(negedge clk);
        tgt_valid = 1'b1; tgt_bit = 1'b1;
        @(negedge clk);
        tgt_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_output("clrchk_in_check", busy, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check_output("clrchk_err", err, 0);
        check_output("clrchk_cnt", err_cnt, 0);

        // A request raised only while busy is not remembered.
        qbar_fb = 1'b0;
        @(negedge clk);
        tgt_valid = 1'b1; tgt_bit = 1'b1;
        @(negedge clk);
        tgt_valid = 1'b0;
        @(negedge clk);
        tgt_valid = 1'b1; tgt_bit = 1'b0;
        @(negedge clk);
        tgt_valid = 1'b0;
        @(negedge clk);
        check_output("ignore_ready", tgt_ready, 1);
        @(negedge clk);
        check_output("ignore_busy", busy, 0);
        check_output("ignore_r", r, 0);
        check_output("ignore_err", err, 0);

        // Repeated failing requests: count climbs, then saturates at 255.
        for (int i = 0; i < 10; i++) apply_stimulus(1'b0);
        check_output("sat_cnt10", err_cnt, 10);
        check_output("sat_err", err, 1);
        for (int i = 10; i < 300; i++) apply_stimulus(1'b0);
        check_output("sat_cnt300", err_cnt, 255);

        // CHECK_LAT=3: reset while s is high drops it at once.
        q_fb_l3 = 1'b0; qbar_fb_l3 = 1'b1;
        @(negedge clk);
        tgt_valid_l3 = 1'b1; tgt_bit_l3 = 1'b1;
        @(negedge clk);
        tgt_valid_l3 = 1'b0;
        check_output("l3_drive_s", s_l3, 1);
        rst_n_l3 = 1'b0;
        #1;
        check_output("l3_rstdrv_s", s_l3, 0);
        check_output("l3_rstdrv_ready", tgt_ready_l3, 1);
        @(negedge clk);
        rst_n_l3 = 1'b1;

        // Reset during WAIT with failing feedback: aborted, nothing counted.
        @(negedge clk);
        tgt_valid_l3 = 1'b1; tgt_bit_l3 = 1'b1;
        @(negedge clk);
        tgt_valid_l3 = 1'b0;
        check_output("l3_again_s", s_l3, 1);
        @(negedge clk);
        check_output("l3_wait_busy", busy_l3, 1);
        rst_n_l3 = 1'b0;
        #1;
        check_output("l3_rstwait_s", s_l3, 0);
        check_output("l3_rstwait_r", r_l3, 0);
        check_output("l3_rstwait_ready", tgt_ready_l3, 1);
        check_output("l3_rstwait_busy", busy_l3, 0);
        repeat (2) @(negedge clk);
        rst_n_l3 = 1'b1;
        check_output("l3_rstwait_err", err_l3, 0);
        check_output("l3_rstwait_cnt", err_cnt_l3, 0);

        // Latency from accepting edge back to tgt_ready high.
        q_fb_l3 = 1'b1; qbar_fb_l3 = 1'b0;
        @(negedge clk);
        tgt_valid_l3 = 1'b1; tgt_bit_l3 = 1'b1;
        @(negedge clk);
        tgt_valid_l3 = 1'b0;
        check_output("l3_lat_s", s_l3, 1);
        n_cyc = 0;
        while (tgt_ready_l3 !== 1'b1 && n_cyc < 20) begin
            @(negedge clk);
            n_cyc++;
        end
        check_output("l3_latency", 8'(n_cyc), 5);
        check_output("l3_lat_err", err_l3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
